// File: rtl/alu_share_arb.sv
// alu_share_arb
// Shares one combinational 32-bit ALU between two requesters: the main execute
// path (requester 0) and the auxiliary address/branch-compare path
// (requester 1). Requests are round-robin arbitrated and registered into an
// operand stage that drives the ALU. The ALU result is then captured into a
// response register with a valid/ready handshake. Throughput is one operation
// per cycle, and accept-to-response latency is 2 cycles.
//
// Parameters:
//   RR_INIT    requester (0 or 1) holding priority after reset
//
// Ports:
//   CLK, Reset_L             clock, synchronous active-low reset
//   ReqValid0/1, ReqReady0/1 request handshakes
//   ReqA0/1, ReqB0/1         operands (A also sources shift amounts)
//   ReqCtrl0/1               ALU control codes
//   AluBusA/B, AluCtrl       operand stage -> ALU (all zero when stage empty)
//   AluBusW, AluZero         ALU result and zero flag
//   RspValid, RspReady       response handshake
//   RspId, RspData, RspZero  captured requester index, result, zero flag
//   RspErr                   illegal control code flag
//
// Optional feature: define ALU_ARB_ILLEGAL_CHK_EN to flag control codes 4'b0101
// and 4'b1111 as illegal. An illegal operation returns RspErr=1 with
// RspData and RspZero forced to zero. Without the macro, RspErr stays 0.

module alu_share_arb #(
  parameter int unsigned RR_INIT = 0
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        ReqValid0,
  input  logic        ReqValid1,
  output logic        ReqReady0,
  output logic        ReqReady1,
  input  logic [31:0] ReqA0,
  input  logic [31:0] ReqA1,
  input  logic [31:0] ReqB0,
  input  logic [31:0] ReqB1,
  input  logic [3:0]  ReqCtrl0,
  input  logic [3:0]  ReqCtrl1,
  output logic [31:0] AluBusA,
  output logic [31:0] AluBusB,
  output logic [3:0]  AluCtrl,
  input  logic [31:0] AluBusW,
  input  logic        AluZero,
  output logic        RspValid,
  input  logic        RspReady,
  output logic        RspId,
  output logic [31:0] RspData,
  output logic        RspZero,
  output logic        RspErr
);

  typedef enum logic {
    PRIO_0 = 1'b0,
    PRIO_1 = 1'b1
  } prio_t;

  localparam prio_t PRIO_RESET = (RR_INIT == 1) ? PRIO_1 : PRIO_0;

  // operand stage
  logic        s1_valid, s1_valid_nxt;
  logic        s1_id,    s1_id_nxt;
  logic [31:0] s1_a,     s1_a_nxt;
  logic [31:0] s1_b,     s1_b_nxt;
  logic [3:0]  s1_ctrl,  s1_ctrl_nxt;

  // response register next values
  logic        rsp_valid_nxt;
  logic        rsp_id_nxt;
  logic [31:0] rsp_data_nxt;
  logic        rsp_zero_nxt;
  logic        rsp_err_nxt;

  prio_t       prio, prio_nxt;

  logic        advance;
  logic        stage_free;
  logic        acc0, acc1;
  logic        illegal;

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_ctrl  <= '0;
      RspValid <= 1'b0;
      RspId    <= 1'b0;
      RspData  <= '0;
      RspZero  <= 1'b0;
      RspErr   <= 1'b0;
      prio     <= PRIO_RESET;
    end else begin
      s1_valid <= s1_valid_nxt;
      s1_id    <= s1_id_nxt;
      s1_a     <= s1_a_nxt;
      s1_b     <= s1_b_nxt;
      s1_ctrl  <= s1_ctrl_nxt;
      RspValid <= rsp_valid_nxt;
      RspId    <= rsp_id_nxt;
      RspData  <= rsp_data_nxt;
      RspZero  <= rsp_zero_nxt;
      RspErr   <= rsp_err_nxt;
      prio     <= prio_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Output logic: request readies and ALU drive
  // ------------------------------------------------------------------
  always_comb begin
    advance    = s1_valid & (~RspValid | RspReady);
    stage_free = ~s1_valid | advance;
    // Each ready looks only at the other requester's valid and the priority
    // pointer, so a requester never sees its own valid looped back.
    ReqReady0  = Reset_L & stage_free & (~ReqValid1 | (prio == PRIO_0));
    ReqReady1  = Reset_L & stage_free & (~ReqValid0 | (prio == PRIO_1));
    acc0       = ReqValid0 & ReqReady0;
    acc1       = ReqValid1 & ReqReady1;

    AluBusA = '0;
    AluBusB = '0;
    AluCtrl = '0;
    if (s1_valid) begin
      AluBusA = s1_a;
      AluBusB = s1_b;
      AluCtrl = s1_ctrl;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
`ifdef ALU_ARB_ILLEGAL_CHK_EN
  always_comb illegal = (s1_ctrl == 4'b0101) || (s1_ctrl == 4'b1111);
`else
  always_comb illegal = 1'b0;
`endif

  always_comb begin
    s1_valid_nxt  = s1_valid;
    s1_id_nxt     = s1_id;
    s1_a_nxt      = s1_a;
    s1_b_nxt      = s1_b;
    s1_ctrl_nxt   = s1_ctrl;
    prio_nxt      = prio;
    rsp_valid_nxt = RspValid;
    rsp_id_nxt    = RspId;
    rsp_data_nxt  = RspData;
    rsp_zero_nxt  = RspZero;
    rsp_err_nxt   = RspErr;

    // The response register either takes the operand stage or drains. A
    // consume in the same cycle as an advance is absorbed by the overwrite.
    if (advance) begin
      rsp_valid_nxt = 1'b1;
      rsp_id_nxt    = s1_id;
      rsp_err_nxt   = illegal;
      rsp_data_nxt  = illegal ? '0 : AluBusW;
      rsp_zero_nxt  = illegal ? 1'b0 : AluZero;
    end else if (RspValid && RspReady) begin
      rsp_valid_nxt = 1'b0;
    end

    // The operand stage reloads on accept, which can coincide with an
    // advance. It empties only when it advances without a replacement.
    if (acc0) begin
      s1_valid_nxt = 1'b1;
      s1_id_nxt    = 1'b0;
      s1_a_nxt     = ReqA0;
      s1_b_nxt     = ReqB0;
      s1_ctrl_nxt  = ReqCtrl0;
      prio_nxt     = PRIO_1;
    end else if (acc1) begin
      s1_valid_nxt = 1'b1;
      s1_id_nxt    = 1'b1;
      s1_a_nxt     = ReqA1;
      s1_b_nxt     = ReqB1;
      s1_ctrl_nxt  = ReqCtrl1;
      prio_nxt     = PRIO_0;
    end else if (advance) begin
      s1_valid_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb. A behavioural ALU drives AluBusW and AluZero.
// The reference model is a queue of accepted operations, plus a flag marking
// whether the head of the queue sits in the response register.
module tb_alu_share_arb;

  localparam int unsigned RRI = 0;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic        ReqValid0, ReqValid1;
  logic        ReqReady0, ReqReady1;
  logic [31:0] ReqA0, ReqA1, ReqB0, ReqB1;
  logic [3:0]  ReqCtrl0, ReqCtrl1;
  logic [31:0] AluBusA, AluBusB;
  logic [3:0]  AluCtrl;
  logic [31:0] AluBusW;
  logic        AluZero;
  logic        RspValid, RspReady;
  logic        RspId;
  logic [31:0] RspData;
  logic        RspZero, RspErr;

  always #5 CLK = ~CLK;

  alu_share_arb #(.RR_INIT(RRI)) dut (
    .CLK(CLK), .Reset_L(Reset_L),
    .ReqValid0(ReqValid0), .ReqValid1(ReqValid1),
    .ReqReady0(ReqReady0), .ReqReady1(ReqReady1),
    .ReqA0(ReqA0), .ReqA1(ReqA1), .ReqB0(ReqB0), .ReqB1(ReqB1),
    .ReqCtrl0(ReqCtrl0), .ReqCtrl1(ReqCtrl1),
    .AluBusA(AluBusA), .AluBusB(AluBusB), .AluCtrl(AluCtrl),
    .AluBusW(AluBusW), .AluZero(AluZero),
    .RspValid(RspValid), .RspReady(RspReady), .RspId(RspId),
    .RspData(RspData), .RspZero(RspZero), .RspErr(RspErr)
  );

  function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      4'b0011: return b << a[4:0];
      4'b0100: return b >> a[4:0];
      4'b1000: return $unsigned($signed(b) >>> a[4:0]);
      default: return a ^ b;
    endcase
  endfunction

  always_comb begin
    AluBusW = alu_f(AluBusA, AluBusB, AluCtrl);
    AluZero = (AluBusW == 32'd0);
  end

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
  } op_t;

  op_t q[$];
  int  grants[$];
  int  ninrsp = 0;
  int  mprio  = RRI;
  bit  inited = 0;
  int  total  = 0;
  int  bad    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void exp_rsp(input op_t e, output logic [31:0] d,
                                  output logic z, output logic er);
    logic ill;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    ill = (e.ctrl == 4'b0101) || (e.ctrl == 4'b1111);
`else
    ill = 1'b0;
`endif
    er = ill;
    d  = ill ? 32'd0 : alu_f(e.a, e.b, e.ctrl);
    z  = ill ? 1'b0 : (d == 32'd0);
  endfunction

  // One clock cycle: check at the falling edge, update the model at the
  // rising edge, and return 1 time unit later so inputs can be changed.
  task automatic step();
    bit          occ, rspv, adv, free, er0, er1;
    op_t         e;
    logic [31:0] d;
    logic        z, er;
    @(negedge CLK);
    occ  = (q.size() > ninrsp);
    rspv = (ninrsp != 0);
    adv  = occ && (!rspv || RspReady);
    free = !occ || adv;
    er0  = Reset_L && free && (!ReqValid1 || mprio == 0);
    er1  = Reset_L && free && (!ReqValid0 || mprio == 1);
    if (inited) begin
      check("ready0", {31'd0, ReqReady0}, {31'd0, er0});
      check("ready1", {31'd0, ReqReady1}, {31'd0, er1});
      check("rsp_valid", {31'd0, RspValid}, {31'd0, rspv});
      if (occ) begin
        e = q[ninrsp];
        check("alu_a", AluBusA, e.a);
        check("alu_b", AluBusB, e.b);
        check("alu_ctrl", {28'd0, AluCtrl}, {28'd0, e.ctrl});
      end else begin
        check("alu_idle", AluBusA | AluBusB | {28'd0, AluCtrl}, 32'd0);
      end
      if (rspv) begin
        e = q[0];
        exp_rsp(e, d, z, er);
        check("rsp_id", {31'd0, RspId}, {31'd0, e.id});
        check("rsp_data", RspData, d);
        check("rsp_zero", {31'd0, RspZero}, {31'd0, z});
        check("rsp_err", {31'd0, RspErr}, {31'd0, er});
      end
    end
    @(posedge CLK);
    if (!Reset_L) begin
      q.delete();
      ninrsp = 0;
      mprio  = RRI;
      inited = 1;
    end else if (inited) begin
      if (rspv && RspReady) begin
        void'(q.pop_front());
        ninrsp = 0;
      end
      if (adv) ninrsp = 1;
      if (ReqValid0 && er0) begin
        q.push_back('{1'b0, ReqA0, ReqB0, ReqCtrl0});
        grants.push_back(0);
        mprio = 1;
      end else if (ReqValid1 && er1) begin
        q.push_back('{1'b1, ReqA1, ReqB1, ReqCtrl1});
        grants.push_back(1);
        mprio = 0;
      end
    end
    #1;
  endtask

  task automatic idle_reqs();
    ReqValid0 = 1'b0;
    ReqValid1 = 1'b0;
  endtask

  initial begin
    Reset_L   = 1'b0;
    ReqValid0 = 1'b1;
    ReqValid1 = 1'b1;
    ReqA0 = 32'd1; ReqB0 = 32'd2; ReqCtrl0 = 4'b0010;
    ReqA1 = 32'd3; ReqB1 = 32'd4; ReqCtrl1 = 4'b0010;
    RspReady  = 1'b1;

    // reset with both requesters valid
    step(); step();
    check("reset_rsp_valid", {31'd0, RspValid}, 32'd0);
    check("reset_rsp_data", RspData, 32'd0);

    // release: RR_INIT requester granted first
    Reset_L = 1'b1;
    grants.delete();
    step();
    check("first_grant_cnt", grants.size(), 1);
    if (grants.size() > 0) check("first_grant", grants[0], RRI);
    idle_reqs();
    repeat (3) step();

    // single op: 5 + 7
    ReqValid0 = 1'b1; ReqA0 = 32'd5; ReqB0 = 32'd7; ReqCtrl0 = 4'b0010;
    step();
    idle_reqs();
    step();
    check("single_valid", {31'd0, RspValid}, 32'd1);
    check("single_data", RspData, 32'd12);
    check("single_zero", {31'd0, RspZero}, 32'd0);
    check("single_id", {31'd0, RspId}, 32'd0);
    step();

    // contention from a fresh reset
    Reset_L = 1'b0; step(); Reset_L = 1'b1;
    ReqA0 = 32'hF0; ReqB0 = 32'h0F; ReqCtrl0 = 4'b0000;
    ReqA1 = 32'd9;  ReqB1 = 32'd9;  ReqCtrl1 = 4'b0110;
    ReqValid0 = 1'b1; ReqValid1 = 1'b1;
    grants.delete();
    repeat (4) step();
    idle_reqs();
    check("cont_grant_cnt", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grants.size()) check("cont_grant", grants[i], (RRI + i) % 2);
    repeat (3) step();

    // backpressure while a stream is pending
    ReqValid0 = 1'b1; ReqValid1 = 1'b1;
    repeat (2) step();
    RspReady = 1'b0;
    repeat (3) step();
    check("bp_parked", q.size(), 2);
    RspReady = 1'b1;
    idle_reqs();
    repeat (4) step();
    check("bp_drained", q.size(), 0);

    // reset with operand stage and response register both full
    RspReady = 1'b0;
    ReqValid0 = 1'b1; ReqA0 = 32'd1; ReqB0 = 32'd1; ReqCtrl0 = 4'b0010;
    repeat (3) step();
    check("mid_full", q.size(), 2);
    Reset_L = 1'b0;
    step();
    Reset_L = 1'b1;
    idle_reqs();
    RspReady = 1'b1;
    check("mid_rsp_valid", {31'd0, RspValid}, 32'd0);
    check("mid_alu_idle", {28'd0, AluCtrl} | AluBusA, 32'd0);
    ReqValid0 = 1'b1; ReqValid1 = 1'b1;
    grants.delete();
    step();
    idle_reqs();
    if (grants.size() > 0) check("mid_prio", grants[0], RRI);
    else check("mid_prio_cnt", grants.size(), 1);
    repeat (3) step();

    // illegal control code
    ReqValid0 = 1'b1; ReqA0 = 32'd3; ReqB0 = 32'd4; ReqCtrl0 = 4'b1111;
    step();
    idle_reqs();
    step();
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    check("illegal_err", {31'd0, RspErr}, 32'd1);
    check("illegal_data", RspData, 32'd0);
`else
    check("illegal_err", {31'd0, RspErr}, 32'd0);
    check("illegal_data", RspData, 32'd7);
`endif
    step();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      Reset_L   = ($urandom_range(0, 99) != 0);
      ReqValid0 = $urandom_range(0, 2) != 0;
      ReqValid1 = $urandom_range(0, 2) != 0;
      ReqA0 = ($urandom_range(0, 3) == 0) ? ReqB0 : $urandom;
      ReqB0 = $urandom;
      ReqA1 = $urandom;
      ReqB1 = ($urandom_range(0, 3) == 0) ? ReqA1 : $urandom;
      ReqCtrl0 = 4'($urandom_range(0, 15));
      ReqCtrl1 = 4'($urandom_range(0, 15));
      RspReady = $urandom_range(0, 3) != 0;
      step();
    end

    Reset_L = 1'b1;
    idle_reqs();
    RspReady = 1'b1;
    repeat (4) step();
    check("final_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
